// File: rtl/levity_pkg.sv
// Shared constants for the levitation array command path: opcodes and cmd_word field layout.
package levity_pkg;

  localparam int LV_DIV_W = 15;

  localparam logic [3:0] OP_DIV   = 4'h1;
  localparam logic [3:0] OP_PHASE = 4'h2;
  localparam logic [3:0] OP_EN    = 4'h3;
  localparam logic [3:0] OP_POL   = 4'h4;

  localparam int CMD_OPC_LSB  = 28;
  localparam int CMD_OPC_W    = 4;
  localparam int CMD_CHAN_LSB = 24;
  localparam int CMD_CHAN_W   = 4;
  localparam int CMD_ARG_LSB  = 0;
  localparam int CMD_ARG_W    = 24;

endpackage

// File: rtl/phase_channel.sv
// One output channel: phase-shifted view of the master count, compared against the half period.
module phase_channel #(
  parameter int DIV_W = 15
) (
  input  logic             clk_100MHz,
  input  logic             RSTN,
  input  logic             i_run,
  input  logic [DIV_W:0]   i_cnt,
  input  logic [DIV_W:0]   i_pm1,
  input  logic [DIV_W-1:0] i_div,
  input  logic [DIV_W-1:0] i_ph,
  input  logic             i_en,
  input  logic             i_pol,
  output logic             o_ch
);

  localparam logic [DIV_W:0] ONE = {{DIV_W{1'b0}}, 1'b1};

  logic [DIV_W:0] w_ph;
  logic [DIV_W:0] w_ph_eff;
  logic [DIV_W:0] w_s;
  logic           w_hi;

  // P may equal 2^(DIV_W+1), so compare against P-1 and let cnt+P-ph wrap modulo the width.
  assign w_ph     = {1'b0, i_ph};
  assign w_ph_eff = (w_ph > i_pm1) ? '0 : w_ph;
  assign w_s      = (i_cnt >= w_ph_eff) ? (i_cnt - w_ph_eff)
                                        : (i_cnt + i_pm1 + ONE - w_ph_eff);
  assign w_hi     = i_en & (w_s < ({1'b0, i_div} + ONE));

  always_ff @(posedge clk_100MHz or negedge RSTN) begin
    if (!RSTN)      o_ch <= 1'b0;
    else if (i_run) o_ch <= w_hi ^ i_pol;
  end

endmodule

// File: rtl/channel_phase_gen.sv
// Multi-channel square-wave generator: command decode, shadow/active settings, master counter.
// Optional: define CH_POLARITY_EN to add the per-channel invert mask (opcode 0x4).
module channel_phase_gen
  import levity_pkg::*;
#(
  parameter int               NUM_CH      = 10,
  parameter int               DIV_W       = LV_DIV_W,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(999)
) (
  input  logic              clk_100MHz,
  input  logic              RSTN,
  input  logic              cmd_valid,
  input  logic [31:0]       cmd_word,
  output logic              cmd_ack,
  output logic              cmd_err,
  output logic [NUM_CH-1:0] CH
);

  localparam logic [CMD_CHAN_W:0] NCH = (CMD_CHAN_W+1)'(NUM_CH);

  logic [CMD_OPC_W-1:0]  w_opc;
  logic [CMD_CHAN_W-1:0] w_chan;
  logic [CMD_ARG_W-1:0]  w_arg;
  logic                  w_ok;
  logic                  w_wr;
  logic                  w_unused_bits;

  logic                         r_run;
  logic [DIV_W:0]               r_cnt;
  logic [DIV_W-1:0]             r_div, r_div_sh;
  logic [NUM_CH-1:0][DIV_W-1:0] r_ph, r_ph_sh;
  logic [NUM_CH-1:0]            r_en, r_en_sh;
  logic [NUM_CH-1:0]            w_pol;
  logic [DIV_W:0]               w_pm1;
  logic                         w_commit;

  assign w_opc  = cmd_word[CMD_OPC_LSB  +: CMD_OPC_W];
  assign w_chan = cmd_word[CMD_CHAN_LSB +: CMD_CHAN_W];
  assign w_arg  = cmd_word[CMD_ARG_LSB  +: CMD_ARG_W];
  assign w_unused_bits = ^w_arg;

  always_comb begin
    w_ok = 1'b0;
    case (w_opc)
      OP_DIV:   w_ok = 1'b1;
      OP_EN:    w_ok = 1'b1;
      OP_PHASE: w_ok = ({1'b0, w_chan} < NCH);
`ifdef CH_POLARITY_EN
      OP_POL:   w_ok = 1'b1;
`endif
      default:  w_ok = 1'b0;
    endcase
  end

  assign w_wr     = cmd_valid & w_ok;
  assign w_pm1    = {r_div, 1'b1};
  assign w_commit = r_run & (r_cnt == w_pm1);

  always_ff @(posedge clk_100MHz or negedge RSTN) begin
    if (!RSTN) begin
      cmd_ack <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      cmd_ack <= cmd_valid & w_ok;
      cmd_err <= cmd_valid & ~w_ok;
    end
  end

  always_ff @(posedge clk_100MHz or negedge RSTN) begin
    if (!RSTN) begin
      r_div_sh <= DEFAULT_DIV;
      r_ph_sh  <= '0;
      r_en_sh  <= '1;
    end else if (w_wr) begin
      if (w_opc == OP_DIV) r_div_sh <= w_arg[DIV_W-1:0];
      if (w_opc == OP_EN)  r_en_sh  <= w_arg[NUM_CH-1:0];
      for (int n = 0; n < NUM_CH; n++)
        if (w_opc == OP_PHASE && w_chan == CMD_CHAN_W'(n))
          r_ph_sh[n] <= w_arg[DIV_W-1:0];
    end
  end

  // First clock after reset release only arms the counter, so CH first rises on the second edge.
  always_ff @(posedge clk_100MHz or negedge RSTN) begin
    if (!RSTN) begin
      r_run <= 1'b0;
      r_cnt <= '0;
      r_div <= DEFAULT_DIV;
      r_ph  <= '0;
      r_en  <= '1;
    end else if (!r_run) begin
      r_run <= 1'b1;
    end else if (w_commit) begin
      r_cnt <= '0;
      r_div <= r_div_sh;
      r_ph  <= r_ph_sh;
      r_en  <= r_en_sh;
    end else begin
      r_cnt <= r_cnt + {{DIV_W{1'b0}}, 1'b1};
    end
  end

`ifdef CH_POLARITY_EN
  logic [NUM_CH-1:0] r_pol, r_pol_sh;

  always_ff @(posedge clk_100MHz or negedge RSTN) begin
    if (!RSTN) begin
      r_pol_sh <= '0;
      r_pol    <= '0;
    end else begin
      if (w_wr && w_opc == OP_POL) r_pol_sh <= w_arg[NUM_CH-1:0];
      if (w_commit)                r_pol    <= r_pol_sh;
    end
  end

  assign w_pol = r_pol;
`else
  assign w_pol = '0;
`endif

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    phase_channel #(.DIV_W(DIV_W)) u_ch (
      .clk_100MHz (clk_100MHz),
      .RSTN       (RSTN),
      .i_run      (r_run),
      .i_cnt      (r_cnt),
      .i_pm1      (w_pm1),
      .i_div      (r_div),
      .i_ph       (r_ph[n]),
      .i_en       (r_en[n]),
      .i_pol      (w_pol[n]),
      .o_ch       (CH[n])
    );
  end

endmodule

// File: tb/tb_channel_phase_gen.sv
// Directed bench for channel_phase_gen; e counts rising edges since reset release, sampled at negedge.
module tb_channel_phase_gen;

  logic        clk_100MHz = 1'b0;
  logic        RSTN       = 1'b0;
  logic        cmd_valid  = 1'b0;
  logic [31:0] cmd_word   = '0;
  logic        cmd_ack;
  logic        cmd_err;
  logic [9:0]  CH;

  int n_run  = 0;
  int n_fail = 0;
  int e      = 0;

  channel_phase_gen dut (
    .clk_100MHz (clk_100MHz),
    .RSTN       (RSTN),
    .cmd_valid  (cmd_valid),
    .cmd_word   (cmd_word),
    .cmd_ack    (cmd_ack),
    .cmd_err    (cmd_err),
    .CH         (CH)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_100MHz);
      e++;
    end
  endtask

  task automatic to(input int n);
    while (e < n) tick(1);
  endtask

  task automatic send(input logic [31:0] w);
    cmd_word  = w;
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic startup(input string tag);
    RSTN = 1'b1;
    e = 0;
    to(1);    chk({tag, " ch_e1"},    32'(CH), 32'h000);
    to(2);    chk({tag, " ch_e2"},    32'(CH), 32'h3FF);
    to(1001); chk({tag, " ch_e1001"}, 32'(CH), 32'h3FF);
    to(1002); chk({tag, " ch_e1002"}, 32'(CH), 32'h000);
  endtask

  initial begin
    tick(3);
    chk("rst ch",  32'(CH),      32'h0);
    chk("rst ack", 32'(cmd_ack), 32'h0);
    chk("rst err", 32'(cmd_err), 32'h0);
    startup("boot");

    // div=4 (P=10), then phase ch1=5 overwritten by ch1=3 within the same period
    send(32'h1000_0004);  chk("div ack", 32'(cmd_ack), 32'h1);
                          chk("div err", 32'(cmd_err), 32'h0);
    tick(1);              chk("ack pulse", 32'(cmd_ack), 32'h0);
    send(32'h2100_0005);  chk("ph5 ack", 32'(cmd_ack), 32'h1);
    send(32'h2100_0003);  chk("ph3 ack", 32'(cmd_ack), 32'h1);

    to(2001); chk("pre commit", 32'(CH), 32'h000);
    to(2002); chk("ph3 k0",     32'(CH), 32'h3FD);
    to(2005); chk("ph3 k3",     32'(CH), 32'h3FF);
    to(2007); chk("ph3 k5",     32'(CH), 32'h002);
    to(2010); chk("ph3 k8",     32'(CH), 32'h000);
    to(2012); chk("ph3 k10",    32'(CH), 32'h3FD);

    // phase 12 >= P is treated as 0
    send(32'h2100_000C);  chk("ph12 ack", 32'(cmd_ack), 32'h1);
    to(2022); chk("ph12 k0", 32'(CH), 32'h3FF);
    to(2027); chk("ph12 k5", 32'(CH), 32'h000);

    // enable write sampled on the commit edge lands one period later
    to(2030);
    send(32'h3000_0001);  chk("en ack", 32'(cmd_ack), 32'h1);
    to(2032); chk("en late k0", 32'(CH), 32'h3FF);
    to(2037); chk("en late k5", 32'(CH), 32'h000);
    to(2042); chk("en k0",      32'(CH), 32'h001);
    to(2046); chk("en k4",      32'(CH), 32'h001);
    to(2047); chk("en k5",      32'(CH), 32'h000);

    send(32'h2A00_0003);  chk("chan10 err", 32'(cmd_err), 32'h1);
                          chk("chan10 ack", 32'(cmd_ack), 32'h0);
    send(32'h7000_0000);  chk("op7 err",    32'(cmd_err), 32'h1);
                          chk("op7 ack",    32'(cmd_ack), 32'h0);
    send(32'h4000_0002);
`ifdef CH_POLARITY_EN
    chk("op4 ack", 32'(cmd_ack), 32'h1);
    chk("op4 err", 32'(cmd_err), 32'h0);
`else
    chk("op4 err", 32'(cmd_err), 32'h1);
    chk("op4 ack", 32'(cmd_ack), 32'h0);
`endif
    tick(1);  chk("err pulse", 32'(cmd_err), 32'h0);
`ifdef CH_POLARITY_EN
    to(2052); chk("pol k0", 32'(CH), 32'h003);
    to(2054); chk("pol k2", 32'(CH), 32'h003);
    to(2057); chk("pol k5", 32'(CH), 32'h002);
`else
    to(2052); chk("after err k0", 32'(CH), 32'h001);
    to(2054); chk("after err k2", 32'(CH), 32'h001);
    to(2057); chk("after err k5", 32'(CH), 32'h000);
`endif

    // mid-period reset: outputs clear at once, defaults come back
    to(2059);
    RSTN = 1'b0;
    #1;
    chk("midrst ch", 32'(CH), 32'h000);
    tick(2);
    chk("midrst ack", 32'(cmd_ack), 32'h0);
    chk("midrst err", 32'(cmd_err), 32'h0);
    startup("rerun");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
